dac_sample_sched: RTL
=====================

Name: dac_sample_sched

Overview:
Sample-rate scheduler that shares the single SPI DAC path (spi2dac) and the PWM generator between two sample requesters.
- On each sample tick from clktick_16, it grants one requester by round-robin and captures that requester's 10-bit sample.
- It issues a one-cycle load to both spi2dac and pwm.
- It then blocks further loads until the SPI transfer has had time to complete, and counts ticks lost while busy.

Parameters:
DW, 10, sample width (matches SW / spi2dac data width)
XFER_CYCLES, 800, CLOCK_50 cycles reserved for one spi2dac transfer after load; legal range 2..1023
OVR_W, 8, width of the saturating overrun counter

Ports:
CLOCK_50  input  1  system clock, 50 MHz
RESET_N  input  1  reset, synchronous, active-low
tick  input  1  one-cycle sample strobe from clktick_16
a_valid  input  1  requester A has a sample
a_data  input  DW  requester A sample
a_ready  output  1  handshake to A
b_valid  input  1  requester B has a sample
b_data  input  DW  requester B sample
b_ready  output  1  handshake to B
dac_data  output  DW  sample to spi2dac and pwm
dac_load  output  1  one-cycle load strobe to spi2dac and pwm
busy  output  1  transfer window active
last_b  output  1  1 = most recent grant went to B
ovr_cnt  output  OVR_W  ticks dropped while not IDLE, saturating
proto_err  output  1  sticky: a granted requester dropped valid

Behaviour:
Reset (RESET_N=0 at a rising edge) forces the following:
- state=IDLE; dac_data=0; dac_load=0; a_ready=b_ready=0; busy=0.
- last_b=1, so A wins the first arbitration; ovr_cnt=0; proto_err=0.
- Reset mid-GRANT or mid-XFER aborts immediately; no load is issued.

FSM states are IDLE, GRANT, LOAD, XFER. All outputs are registered.

IDLE:
- If tick=1 and (a_valid|b_valid) in cycle T, register the grant winner and go to GRANT.
- Winner rule: if only one requester is valid, it wins. If both are valid, the winner is A when last_b=1 and B when last_b=0.
- If tick=1 with no valid requester: no grant, no load, stay in IDLE; dac_data holds its last value.

GRANT (cycle T+1):
- The winner's ready is 1 for exactly this cycle; the other ready stays 0.
- If the winner's valid=1: capture its data into dac_data, update last_b, go to LOAD.
- If the winner's valid=0: set proto_err=1, go to IDLE; no load, last_b unchanged.

LOAD (cycle T+2):
- dac_load=1 for exactly one cycle; busy=1; load the counter with XFER_CYCLES-1; go to XFER.

XFER:
- busy=1; the counter decrements each cycle.
- When the counter reaches 0, go to IDLE, with busy=0 from the next cycle.
- Total busy time is XFER_CYCLES cycles, starting with LOAD.

Requester protocol:
- A requester holds valid and data stable from assertion until it sees ready.
- A valid held across multiple ticks is granted at most once per tick.

Overrun:
- A tick arriving in GRANT, LOAD or XFER is dropped: ovr_cnt += 1, saturating at 2^OVR_W-1.
- A tick in the same cycle as the XFER→IDLE transition also counts as dropped; it is not used to start a grant.

dac_data:
- Changes only in GRANT when a capture occurs, and is stable for the whole XFER window.

Throughput limit:
- Minimum tick-to-tick spacing without overrun is XFER_CYCLES+3 cycles.

Decomposition:
Shared package dac_sched_pkg holds:
- the state encoding (IDLE, GRANT, LOAD, XFER);
- DW default 10;
- XFER_CYCLES default 800;
- counter width 10.

One natural sub-module is rr_arb2: a combinational two-request round-robin picker. Its inputs are req[1:0] and last_b; its outputs are gnt_a and gnt_b. The FSM registers its result.

Test Plan:
1. Reset, then a_valid=1 with a_data=10'h155 and tick at cycle T. Required: a_ready=1 at T+1; dac_load=1 with dac_data=10'h155 at T+2; busy high for 800 cycles; last_b=0.
2. Both valid, A=10'h0AA, B=10'h3FF, four ticks spaced 900 cycles apart. Required grant order A,B,A,B; dac_data sequence 0AA,3FF,0AA,3FF; each ready pulse is exactly 1 cycle.
3. Ticks every 100 cycles, A always valid. Required: one load per 803-cycle window; ovr_cnt increments for each dropped tick; with OVR_W=2, ovr_cnt saturates at 3.
4. Tick with no valid requester. Required: no ready, no dac_load, dac_data unchanged, ovr_cnt unchanged.
5. a_valid deasserted in the GRANT cycle. Required: proto_err=1, no dac_load, state returns to IDLE; the next valid tick is still granted to A.
6. RESET_N low for one cycle at XFER cycle 400. Required: next cycle busy=0, ovr_cnt=0, last_b=1; a subsequent tick with B-only valid grants B with a load at T+2.

Source files
------------

// File: rtl/dac_sched_pkg.sv
// Shared definitions for the DAC sample scheduler: FSM encoding, default
// widths and the transfer-window counter width.
package dac_sched_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_LOAD  = 2'd2,
    S_XFER  = 2'd3
  } state_t;

  localparam int DW_DEFAULT          = 10;
  localparam int XFER_CYCLES_DEFAULT = 800;
  localparam int OVR_W_DEFAULT       = 8;
  localparam int CNT_W               = 10;

endpackage

// File: rtl/dac_sample_sched_rr_arb2.sv
// Combinational two-way round-robin picker; req[0] is requester A,
// req[1] is requester B. The scheduler registers the result.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last_b,
  output logic       gnt_a,
  output logic       gnt_b
);

  // On contention the requester that was not served last time wins.
  assign gnt_a = req[0] & (~req[1] | last_b);
  assign gnt_b = req[1] & (~req[0] | ~last_b);

endmodule

// File: rtl/dac_sample_sched.sv
// Shares one spi2dac/pwm load path between two sample requesters, granting
// round-robin on each sample tick and holding off loads for a transfer window.
module dac_sample_sched
  import dac_sched_pkg::*;
#(
  parameter int DW          = DW_DEFAULT,
  parameter int XFER_CYCLES = XFER_CYCLES_DEFAULT,
  parameter int OVR_W       = OVR_W_DEFAULT
) (
  input  logic             CLOCK_50,
  input  logic             RESET_N,
  input  logic             tick,
  input  logic             a_valid,
  input  logic [DW-1:0]    a_data,
  output logic             a_ready,
  input  logic             b_valid,
  input  logic [DW-1:0]    b_data,
  output logic             b_ready,
  output logic [DW-1:0]    dac_data,
  output logic             dac_load,
  output logic             busy,
  output logic             last_b,
  output logic [OVR_W-1:0] ovr_cnt,
  output logic             proto_err
);

  localparam logic [CNT_W-1:0] XFER_LOAD = CNT_W'(XFER_CYCLES - 1);

  state_t             r_state, w_state_nxt;
  logic               r_win_b, w_win_b_nxt;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
  logic [DW-1:0]      r_dac_data, w_dac_data_nxt;
  logic               r_a_ready, w_a_ready_nxt;
  logic               r_b_ready, w_b_ready_nxt;
  logic               r_dac_load, w_dac_load_nxt;
  logic               r_busy, w_busy_nxt;
  logic               r_last_b, w_last_b_nxt;
  logic [OVR_W-1:0]   r_ovr_cnt, w_ovr_cnt_nxt;
  logic               r_proto_err, w_proto_err_nxt;

  logic               w_gnt_a, w_gnt_b;
  logic               w_win_valid;

  rr_arb2 u_arb (
    .req    ({b_valid, a_valid}),
    .last_b (r_last_b),
    .gnt_a  (w_gnt_a),
    .gnt_b  (w_gnt_b)
  );

  assign w_win_valid = r_win_b ? b_valid : a_valid;

  always_ff @(posedge CLOCK_50) begin
    if (!RESET_N) begin
      r_state     <= S_IDLE;
      r_win_b     <= 1'b0;
      r_cnt       <= '0;
      r_dac_data  <= '0;
      r_a_ready   <= 1'b0;
      r_b_ready   <= 1'b0;
      r_dac_load  <= 1'b0;
      r_busy      <= 1'b0;
      r_last_b    <= 1'b1;
      r_ovr_cnt   <= '0;
      r_proto_err <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_win_b     <= w_win_b_nxt;
      r_cnt       <= w_cnt_nxt;
      r_dac_data  <= w_dac_data_nxt;
      r_a_ready   <= w_a_ready_nxt;
      r_b_ready   <= w_b_ready_nxt;
      r_dac_load  <= w_dac_load_nxt;
      r_busy      <= w_busy_nxt;
      r_last_b    <= w_last_b_nxt;
      r_ovr_cnt   <= w_ovr_cnt_nxt;
      r_proto_err <= w_proto_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_win_b_nxt     = r_win_b;
    w_cnt_nxt       = r_cnt;
    w_dac_data_nxt  = r_dac_data;
    w_a_ready_nxt   = 1'b0;
    w_b_ready_nxt   = 1'b0;
    w_dac_load_nxt  = 1'b0;
    w_busy_nxt      = 1'b0;
    w_last_b_nxt    = r_last_b;
    w_ovr_cnt_nxt   = r_ovr_cnt;
    w_proto_err_nxt = r_proto_err;

    // Any tick outside IDLE is lost, including the final XFER cycle.
    if (tick && (r_state != S_IDLE) && (r_ovr_cnt != '1)) begin
      w_ovr_cnt_nxt = r_ovr_cnt + 1'b1;
    end

    case (r_state)
      S_IDLE: begin
        if (tick && (a_valid || b_valid)) begin
          w_state_nxt   = S_GRANT;
          w_win_b_nxt   = w_gnt_b;
          w_a_ready_nxt = w_gnt_a;
          w_b_ready_nxt = w_gnt_b;
        end
      end
      S_GRANT: begin
        if (w_win_valid) begin
          w_dac_data_nxt = r_win_b ? b_data : a_data;
          w_last_b_nxt   = r_win_b;
          w_dac_load_nxt = 1'b1;
          w_busy_nxt     = 1'b1;
          w_state_nxt    = S_LOAD;
        end else begin
          w_proto_err_nxt = 1'b1;
          w_state_nxt     = S_IDLE;
        end
      end
      S_LOAD: begin
        w_busy_nxt  = 1'b1;
        w_cnt_nxt   = XFER_LOAD;
        w_state_nxt = S_XFER;
      end
      S_XFER: begin
        // busy drops one cycle before leaving XFER so the window is exactly
        // XFER_CYCLES long counting the LOAD cycle.
        if (r_cnt == '0) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_cnt_nxt  = r_cnt - 1'b1;
          w_busy_nxt = (r_cnt != CNT_W'(1));
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign a_ready   = r_a_ready;
  assign b_ready   = r_b_ready;
  assign dac_data  = r_dac_data;
  assign dac_load  = r_dac_load;
  assign busy      = r_busy;
  assign last_b    = r_last_b;
  assign ovr_cnt   = r_ovr_cnt;
  assign proto_err = r_proto_err;

endmodule
